// File: rtl/lcd_frame_arbiter.sv
// Frame-aligned arbiter sharing the spi_lcd pixel port between N_SRC sources; ownership moves only at start of frame.
// Optional forced rotation of long-held owners is enabled by defining LCD_ARB_STARVE_EN.
module lcd_frame_arbiter #(
  parameter int          N_SRC       = 4,
  parameter int          LCD_W       = 132,
  parameter int          LCD_H       = 162,
  parameter int          MIN_HOLD    = 2,
  parameter int          MAX_HOLD    = 30,
  parameter logic [15:0] BLANK_COLOR = 16'h0000,
  localparam int         IDW         = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         ram_addr_x_i,
  input  logic [7:0]         ram_addr_y_i,
  input  logic [N_SRC-1:0]   req_i,
  input  logic [16*N_SRC-1:0] src_data_i,
  output logic [N_SRC-1:0]   grant_o,
  output logic [IDW-1:0]     owner_id_o,
  output logic               owner_valid_o,
  output logic               switch_pulse_o,
  output logic               sof_pulse_o,
  output logic [15:0]        ram_data_o
);

  typedef enum logic {FREE, OWNED} state_e;

  localparam logic [7:0] MIN_HOLD_C = 8'(MIN_HOLD);
  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);
`ifdef LCD_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif
  // An 8-bit address cannot describe a larger panel; such a build never sees a frame start.
  localparam bit GEOM_OK = (LCD_W <= 256) && (LCD_H <= 256);

  state_e             state_q, state_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [7:0]         hold_q, hold_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic               switch_q, switch_d;
  logic               sof_q;
  logic               at_origin_q;

  logic               at_origin, sof;
  logic               any_req, owner_req, other_req, lower_req, rot_found;
  logic [IDW-1:0]     lowest_idx, rot_idx, cand_idx;

  assign at_origin = GEOM_OK && (ram_addr_x_i == 8'd0) && (ram_addr_y_i == 8'd0);
  assign sof       = at_origin & ~at_origin_q;

  always_comb begin
    any_req    = |req_i;
    lowest_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) lowest_idx = IDW'(i);
    end
    owner_req = 1'b0;
    other_req = 1'b0;
    lower_req = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (IDW'(i) == owner_q) owner_req = req_i[i];
      else if (req_i[i])      other_req = 1'b1;
      if (req_i[i] && (IDW'(i) < owner_q)) lower_req = 1'b1;
    end
    // Round-robin search starts just above the current owner and wraps.
    rot_idx   = owner_q;
    rot_found = 1'b0;
    cand_idx  = '0;
    for (int k = 1; k < N_SRC; k++) begin
      cand_idx = IDW'((int'(owner_q) + k) % N_SRC);
      if (!rot_found && req_i[cand_idx]) begin
        rot_idx   = cand_idx;
        rot_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    if (sof) begin
      case (state_q)
        FREE: begin
          if (any_req) begin
            state_d = OWNED;
            owner_d = lowest_idx;
            hold_d  = 8'd0;
          end
        end
        OWNED: begin
          if (STARVE_EN && (hold_q >= MAX_HOLD_C) && other_req) begin
            owner_d = rot_idx;
            hold_d  = 8'd0;
          end else if (!owner_req) begin
            hold_d = 8'd0;
            if (any_req) owner_d = lowest_idx;
            else         state_d = FREE;
          end else if (lower_req && (hold_q >= MIN_HOLD_C)) begin
            owner_d = lowest_idx;
            hold_d  = 8'd0;
          end else if (hold_q != 8'hFF) begin
            hold_d = hold_q + 8'd1;
          end
        end
        default: state_d = FREE;
      endcase
    end
    switch_d = sof && ((state_d != state_q) || (owner_d != owner_q));
    grant_d  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      grant_d[i] = (state_d == OWNED) && (owner_d == IDW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FREE;
      owner_q     <= '0;
      hold_q      <= 8'd0;
      grant_q     <= '0;
      switch_q    <= 1'b0;
      sof_q       <= 1'b0;
      at_origin_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      hold_q      <= hold_d;
      grant_q     <= grant_d;
      switch_q    <= switch_d;
      sof_q       <= sof;
      at_origin_q <= at_origin;
    end
  end

  always_comb begin
    ram_data_o = BLANK_COLOR;
    for (int i = 0; i < N_SRC; i++) begin
      if ((state_q == OWNED) && (owner_q == IDW'(i))) ram_data_o = src_data_i[16*i +: 16];
    end
  end

  assign grant_o        = grant_q;
  assign owner_id_o     = owner_q;
  assign owner_valid_o  = (state_q == OWNED);
  assign switch_pulse_o = switch_q;
  assign sof_pulse_o    = sof_q;

endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// Directed bench for lcd_frame_arbiter: reset, frame-aligned switching, preemption, idle, frozen address, starvation.
module tb_lcd_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  addr_x = 8'd3;
  logic [7:0]  addr_y = 8'd3;
  logic [3:0]  req = 4'b0000;
  logic [63:0] src_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
  logic [3:0]  grant;
  logic [1:0]  owner_id;
  logic        owner_valid, switch_pulse, sof_pulse;
  logic [15:0] ram_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lcd_frame_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ram_addr_x_i   (addr_x),
    .ram_addr_y_i   (addr_y),
    .req_i          (req),
    .src_data_i     (src_data),
    .grant_o        (grant),
    .owner_id_o     (owner_id),
    .owner_valid_o  (owner_valid),
    .switch_pulse_o (switch_pulse),
    .sof_pulse_o    (sof_pulse),
    .ram_data_o     (ram_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leave the origin for two cycles, then hit (0,0); returns just after the edge ending the sof cycle.
  task automatic go_sof();
    addr_x = 8'd7; addr_y = 8'd3;
    step(); step();
    addr_x = 8'd0; addr_y = 8'd0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; addr_x = 8'd3; addr_y = 8'd3;
    #12;
    vectors++;
    if (grant !== 4'b0000 || owner_valid !== 1'b0 || owner_id !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state got grant=%b valid=%b id=%0d exp 0000/0/0", grant, owner_valid, owner_id);
    end
    vectors++;
    if (ram_data !== 16'h0000 || switch_pulse !== 1'b0 || sof_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_data got ram=%h sw=%b sof=%b exp 0000/0/0", ram_data, switch_pulse, sof_pulse);
    end
    @(negedge clk); rst_n = 1'b1;
    step();
    vectors++;
    if (grant !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_nosof got grant=%b exp 0000", grant);
    end
    addr_x = 8'd0; addr_y = 8'd0;
    step();
    vectors++;
    if (grant !== 4'b0001 || switch_pulse !== 1'b1 || sof_pulse !== 1'b1 || ram_data !== 16'h1111) begin
      miscompares++;
      $display("FAIL reset_first_sof got grant=%b sw=%b sof=%b ram=%h exp 0001/1/1/1111",
               grant, switch_pulse, sof_pulse, ram_data);
    end
    step();
    vectors++;
    if (switch_pulse !== 1'b0 || sof_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pulse_width got sw=%b sof=%b exp 0/0", switch_pulse, sof_pulse);
    end
  endtask

  task automatic test_frame_switch();
    req = 4'b0100;
    go_sof();
    vectors++;
    if (grant !== 4'b0100 || owner_id !== 2'd2 || switch_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL sw_to2 got grant=%b id=%0d sw=%b exp 0100/2/1", grant, owner_id, switch_pulse);
    end
    addr_x = 8'd40; addr_y = 8'd80; req = 4'b1000;
    step(); step();
    vectors++;
    if (grant !== 4'b0100 || ram_data !== 16'h3333 || switch_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL sw_midframe got grant=%b ram=%h sw=%b exp 0100/3333/0", grant, ram_data, switch_pulse);
    end
    go_sof();
    vectors++;
    if (grant !== 4'b1000 || ram_data !== 16'h4444 || switch_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL sw_to3 got grant=%b ram=%h sw=%b exp 1000/4444/1", grant, ram_data, switch_pulse);
    end
  endtask

  task automatic test_preempt();
    addr_x = 8'd10; addr_y = 8'd10; req = 4'b1010;
    step();
    go_sof();
    vectors++;
    if (grant !== 4'b1000 || switch_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_sof1 got grant=%b sw=%b exp 1000/0", grant, switch_pulse);
    end
    go_sof();
    vectors++;
    if (grant !== 4'b1000 || switch_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_sof2 got grant=%b sw=%b exp 1000/0", grant, switch_pulse);
    end
    go_sof();
    vectors++;
    if (grant !== 4'b0010 || owner_id !== 2'd1 || switch_pulse !== 1'b1 || ram_data !== 16'h2222) begin
      miscompares++;
      $display("FAIL pre_sof3 got grant=%b id=%0d sw=%b ram=%h exp 0010/1/1/2222",
               grant, owner_id, switch_pulse, ram_data);
    end
  endtask

  task automatic test_idle();
    addr_x = 8'd9; addr_y = 8'd9; req = 4'b0000;
    step();
    go_sof();
    vectors++;
    if (owner_valid !== 1'b0 || grant !== 4'b0000 || ram_data !== 16'h0000 || switch_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_free got valid=%b grant=%b ram=%h sw=%b exp 0/0000/0000/1",
               owner_valid, grant, ram_data, switch_pulse);
    end
    addr_x = 8'd20; addr_y = 8'd20;
    step();
    req = 4'b0001;
    for (int i = 0; i < 5; i++) step();
    req = 4'b0000;
    vectors++;
    if (grant !== 4'b0000 || owner_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_glitch_mid got grant=%b valid=%b exp 0000/0", grant, owner_valid);
    end
    go_sof();
    vectors++;
    if (grant !== 4'b0000 || owner_valid !== 1'b0 || switch_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_glitch_sof got grant=%b valid=%b sw=%b exp 0000/0/0", grant, owner_valid, switch_pulse);
    end
  endtask

  task automatic test_frozen();
    int sofs = 0;
    int sws = 0;
    addr_x = 8'd5; addr_y = 8'd0; req = 4'b0001;
    step();
    addr_x = 8'd0;
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) req = 4'b0100;
      step();
      if (sof_pulse === 1'b1) sofs++;
      if (switch_pulse === 1'b1) sws++;
    end
    vectors++;
    if (sofs !== 1) begin
      miscompares++;
      $display("FAIL frozen_sof_count got %0d exp 1", sofs);
    end
    vectors++;
    if (sws !== 1 || grant !== 4'b0001) begin
      miscompares++;
      $display("FAIL frozen_switch got count=%0d grant=%b exp 1/0001", sws, grant);
    end
    go_sof();
    vectors++;
    if (grant !== 4'b0100 || switch_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL frozen_return got grant=%b sw=%b exp 0100/1", grant, switch_pulse);
    end
  endtask

  task automatic test_starvation();
    int bad = 0;
    int sws = 0;
    addr_x = 8'd1; addr_y = 8'd1; req = 4'b0011;
    step();
    go_sof();
    vectors++;
    if (grant !== 4'b0001 || switch_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL starve_grant0 got grant=%b sw=%b exp 0001/1", grant, switch_pulse);
    end
`ifdef LCD_ARB_STARVE_EN
    for (int f = 1; f <= 30; f++) begin
      go_sof();
      if (grant !== 4'b0001) bad++;
      if (switch_pulse === 1'b1) sws++;
    end
    vectors++;
    if (bad !== 0 || sws !== 0) begin
      miscompares++;
      $display("FAIL starve_hold got wrong_frames=%0d switches=%0d exp 0/0", bad, sws);
    end
    go_sof();
    vectors++;
    if (grant !== 4'b0010 || switch_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL starve_rotate got grant=%b sw=%b exp 0010/1", grant, switch_pulse);
    end
    go_sof(); go_sof();
    vectors++;
    if (grant !== 4'b0010) begin
      miscompares++;
      $display("FAIL starve_minhold got grant=%b exp 0010", grant);
    end
    go_sof();
    vectors++;
    if (grant !== 4'b0001 || switch_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL starve_back0 got grant=%b sw=%b exp 0001/1", grant, switch_pulse);
    end
`else
    for (int f = 1; f <= 100; f++) begin
      go_sof();
      if (grant !== 4'b0001) bad++;
      if (switch_pulse === 1'b1) sws++;
    end
    vectors++;
    if (bad !== 0 || sws !== 0) begin
      miscompares++;
      $display("FAIL nostarve_hold got wrong_frames=%0d switches=%0d exp 0/0", bad, sws);
    end
`endif
  endtask

  task automatic test_reset_midframe();
    addr_x = 8'd30; addr_y = 8'd30;
    step();
    @(negedge clk); rst_n = 1'b0;
    #1;
    vectors++;
    if (grant !== 4'b0000 || owner_valid !== 1'b0 || ram_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_mid got grant=%b valid=%b ram=%h exp 0000/0/0000", grant, owner_valid, ram_data);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_frame_switch();
    test_preempt();
    test_idle();
    test_frozen();
    test_starvation();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
